// File: rtl/store_buffer_unit.sv
// store_buffer_unit: aligned store FIFO to data memory; define STORE_BUF_FWD_EN to enable ld_conflict
module store_buffer_unit #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [1:0]                 st_funct3,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [XLEN-1:0]            st_data,
  output logic                       st_err,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [XLEN-1:0]            mem_wdata,
  output logic [XLEN/8-1:0]          mem_be,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_conflict
);
  localparam int OB = XLEN / 8;
  localparam int OW = $clog2(OB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [XLEN-1:0]   q_data [DEPTH];
  logic [OB-1:0]     q_be   [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [OW-1:0]     off;
  logic [7:0]        m8;
  logic              mis, push, pop;
  assign off = st_addr[OW-1:0];
  always_comb begin
    m8 = st_funct3 == 2'b00 ? 8'h01 : st_funct3 == 2'b01 ? 8'h03 : st_funct3 == 2'b10 ? 8'h0f : 8'hff;
    mis = (st_funct3 == 2'b01 && st_addr[0]) ||
          (st_funct3 == 2'b10 && st_addr[1:0] != 2'b00) ||
          (st_funct3 == 2'b11 && (XLEN == 32 || st_addr[2:0] != 3'b000));
  end
  assign full      = count == CW'(DEPTH);
  assign empty     = count == '0;
  assign st_ready  = !full;
  assign mem_valid = !empty;
  assign push      = st_valid && st_ready && !mis;
  assign pop       = mem_valid && mem_ready;
  assign mem_addr  = q_addr[rd_ptr];
  assign mem_wdata = q_data[rd_ptr];
  assign mem_be    = q_be[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= st_addr & ~ADDR_W'(OB - 1);
      q_data[wr_ptr] <= st_data << {off, 3'b000};
      q_be[wr_ptr]   <= m8[OB-1:0] << off;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      st_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
      st_err <= st_valid && st_ready && mis;
    end
  end
`ifdef STORE_BUF_FWD_EN
  logic [DEPTH-1:0] vld;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= '0;
    else begin
      if (push) vld[wr_ptr] <= 1'b1;
      if (pop) vld[rd_ptr] <= 1'b0;
    end
  end
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && q_addr[i] == (ld_addr & ~ADDR_W'(OB - 1))) ld_conflict = 1'b1;
  end
`else
  logic unused_ld;
  assign unused_ld   = ^ld_addr;
  assign ld_conflict = 1'b0;
`endif
endmodule

// File: tb/tb_store_buffer_unit.sv
// tb_store_buffer_unit: directed checks of a 32-bit and a 64-bit store buffer
module tb_store_buffer_unit;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic st_valid = 0, mem_ready = 0, st_ready, st_err, mem_valid, empty, full, ld_conflict;
  logic [1:0] st_funct3 = 0;
  logic [31:0] st_addr = 0, st_data = 0, mem_addr, mem_wdata, ld_addr = 0;
  logic [3:0] mem_be;
  logic [2:0] count;
  logic v64 = 0, mr64 = 0, rdy64, err64, mv64, e64, f64, c64;
  logic [1:0] fn64 = 0;
  logic [31:0] a64 = 0, ma64;
  logic [63:0] d64 = 0, wd64;
  logic [7:0] be64;
  logic [2:0] cnt64;
  int errors = 0, checks = 0;
  logic fwd;
  logic [31:0] q[$];
  logic [31:0] a;

  store_buffer_unit u32 (.clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data), .st_err(st_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .count(count), .empty(empty), .full(full), .ld_addr(ld_addr),
    .ld_conflict(ld_conflict));

  store_buffer_unit #(.XLEN(64)) u64 (.clk(clk), .rst_n(rst_n), .st_valid(v64), .st_ready(rdy64),
    .st_funct3(fn64), .st_addr(a64), .st_data(d64), .st_err(err64),
    .mem_valid(mv64), .mem_ready(mr64), .mem_addr(ma64), .mem_wdata(wd64),
    .mem_be(be64), .count(cnt64), .empty(e64), .full(f64), .ld_addr(32'h0),
    .ld_conflict(c64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] f, input logic [31:0] ad, input logic [31:0] d);
    st_valid = 1; st_funct3 = f; st_addr = ad; st_data = d;
    @(negedge clk);
    st_valid = 0;
  endtask

  task automatic pop1();
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
  endtask

  initial begin
`ifdef STORE_BUF_FWD_EN
    fwd = 1;
`else
    fwd = 0;
`endif
    #12;
    chk("rst_count", count, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_mvalid", mem_valid, 0); chk("rst_ready", st_ready, 1); chk("rst_err", st_err, 0);
    @(negedge clk); rst_n = 1; @(negedge clk);
    // sb at byte 3
    push(2'b00, 32'h103, 32'hab);
    chk("sb_valid", mem_valid, 1); chk("sb_addr", mem_addr, 32'h100);
    chk("sb_be", mem_be, 4'b1000); chk("sb_wdata", mem_wdata, 32'hab000000); chk("sb_count", count, 1);
    pop1(); chk("sb_drained", empty, 1);
    push(2'b01, 32'h102, 32'h1234);
    chk("sh_be", mem_be, 4'b1100); chk("sh_wdata", mem_wdata, 32'h12340000); chk("sh_addr", mem_addr, 32'h100);
    pop1();
    push(2'b10, 32'h101, 32'h55);
    chk("mis_err", st_err, 1); chk("mis_count", count, 0); chk("mis_valid", mem_valid, 0);
    @(negedge clk); chk("mis_err_pulse", st_err, 0);
    // fill to full with memory stalled
    for (int i = 0; i < 4; i++) push(2'b10, 32'h10 + 4 * i, i + 1);
    chk("full", full, 1); chk("full_ready", st_ready, 0); chk("full_count", count, 4);
    st_valid = 1; st_funct3 = 2'b10; st_addr = 32'h20; st_data = 5;
    @(negedge clk); st_valid = 0;
    chk("held_count", count, 4); chk("held_err", st_err, 0);
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", mem_addr, 32'h10 + 4 * i); chk("drain_data", mem_wdata, i + 1);
      @(negedge clk);
    end
    mem_ready = 0;
    chk("drain_empty", empty, 1);
    // simultaneous push/pop with pointer wrap
    q = {};
    for (int i = 0; i < 2; i++) begin a = 32'h80 + 4 * i; push(2'b10, a, a); q.push_back(a); end
    for (int k = 0; k < 10; k++) begin
      chk("pp_addr", mem_addr, q[0]); chk("pp_data", mem_wdata, q[0]);
      a = 32'h100 + 4 * k;
      st_valid = 1; st_funct3 = 2'b10; st_addr = a; st_data = a; mem_ready = 1;
      @(negedge clk);
      void'(q.pop_front()); q.push_back(a);
      chk("pp_count", count, 2);
    end
    st_valid = 0;
    for (int i = 0; i < 2; i++) begin chk("pp_tail", mem_addr, q[i]); @(negedge clk); end
    mem_ready = 0;
    chk("pp_empty", empty, 1);
    // sd illegal on 32-bit, legal on 64-bit
    push(2'b11, 32'h208, 32'h1);
    chk("sd32_err", st_err, 1); chk("sd32_count", count, 0);
    v64 = 1; fn64 = 2'b11; a64 = 32'h208; d64 = 64'h1122334455667788;
    @(negedge clk); v64 = 0;
    chk("sd64_err", err64, 0); chk("sd64_be", be64, 8'hff); chk("sd64_addr", ma64, 32'h208);
    chk("sd64_wdata", wd64, 64'h1122334455667788);
    mr64 = 1; @(negedge clk); mr64 = 0;
    v64 = 1; fn64 = 2'b10; a64 = 32'h20c; d64 = 64'hdeadbeef;
    @(negedge clk); v64 = 0;
    chk("sw64_be", be64, 8'hf0); chk("sw64_addr", ma64, 32'h208); chk("sw64_wdata", wd64, 64'hdeadbeef00000000);
    v64 = 1; fn64 = 2'b11; a64 = 32'h204; d64 = 64'h1;
    @(negedge clk); v64 = 0;
    chk("sd64_mis_err", err64, 1); chk("sd64_mis_count", cnt64, 1);
    // forwarding hazard
    push(2'b10, 32'h40, 32'h9);
    ld_addr = 32'h42; #1 chk("ldc_hit", ld_conflict, fwd);
    ld_addr = 32'h44; #1 chk("ldc_miss", ld_conflict, 0);
    ld_addr = 32'h42;
    @(negedge clk); pop1(); chk("ldc_drained", ld_conflict, 0);
    // async reset with entries queued
    for (int i = 0; i < 3; i++) push(2'b10, 32'h300 + 4 * i, i);
    chk("pre_rst_count", count, 3);
    #2 rst_n = 0;
    #1 chk("arst_count", count, 0); chk("arst_mvalid", mem_valid, 0); chk("arst_64", mv64, 0);
    @(negedge clk); rst_n = 1; @(negedge clk);
    chk("post_rst_empty", empty, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
